mips_prog_loader: RTL and testbench

//  Hardware program loader for the MIPS single-cycle CPU: the write-side counterpart of the

---
 rtl/mips_prog_loader.sv | 189 ++++++++++++++++++
 tb/tb_mips_prog_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: 2-byte little-endian word count, then little-endian words into imem.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module mips_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    CSUM   = 3'd4,
`endif
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] n_words;
  logic [ADDR_W:0]  word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      wbuf;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic        xfer;
  logic [15:0] len_val;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign len_val   = {in_data, n_words[7:0]};
  assign last_word = ((32'(word_idx) + 32'd1) == 32'(n_words));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst   <= 1'b1;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      wbuf      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LEN_LO;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_rst  <= 1'b1;
            n_words  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        LEN_LO: begin
          if (xfer) begin
            n_words <= LEN_W'(in_data);
`ifdef PROG_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_data;
`endif
            state   <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            n_words <= LEN_W'(len_val);
`ifdef PROG_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_data;
`endif
            if (32'(len_val) > 32'(MAX_WORDS)) begin
              state    <= ERROR;
              error    <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (len_val == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state    <= CSUM;
`else
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_rst  <= 1'b0;
              in_ready <= 1'b0;
`endif
            end else begin
              state    <= DATA;
              word_idx <= '0;
              byte_idx <= '0;
            end
          end
        end

        DATA: begin
          // in_ready low in DATA only happens during the final word's write cycle
          if (!in_ready) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            cpu_rst <= 1'b0;
          end else if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= {word_idx[ADDR_W-1:0], 2'b00};
              mem_wdata <= {in_data, wbuf};
              word_idx  <= word_idx + 1'b1;
              byte_idx  <= 2'd0;
              if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state    <= CSUM;
`else
                in_ready <= 1'b0;
`endif
              end
            end else begin
              wbuf[8*byte_idx +: 8] <= in_data;
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state   <= ERROR;
              error   <= 1'b1;
              cpu_rst <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: expected writes queued at stimulus time, popped on mem_we.
module tb_mips_prog_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W+1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_rst;

  mips_prog_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int errors = 0;
  int checks = 0;
  int writes = 0;
  int stalls = 0;
`ifdef PROG_LOADER_CHECKSUM_EN
  bit use_csum = 1'b1;
`else
  bit use_csum = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      writes++;
      check("we_while_done", 64'(done), 64'd0);
      if (exp_q.size() == 0) begin
        check("extra_we", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    stalls += n;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic load(input bit throttle, input bit add_csum);
    logic [7:0] x = 8'h00;
    foreach (stim[i]) begin
      send(stim[i]);
      x ^= stim[i];
      if (throttle) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    if (add_csum && use_csum) send(x);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!done && !error && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check(tag, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input string tag, input int nwr);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_writes"}, 64'(writes), 64'(nwr));
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with a byte offered: nothing may be consumed
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // two-word image, back-to-back
    stim = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
    exp_q.push_back('{32'd0, 32'h05000820});
    exp_q.push_back('{32'd4, 32'h040001AC});
    writes = 0; stalls = 0;
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_cpu_rst", 64'(cpu_rst), 64'd1);
    load(1'b0, 1'b1);
    check("b2b_stalls", 64'(stalls), 64'd0);
    wait_end("b2b_timeout");
    expect_done("b2b", 2);

    // same image, valid one cycle in three
    exp_q.push_back('{32'd0, 32'h05000820});
    exp_q.push_back('{32'd4, 32'h040001AC});
    writes = 0;
    pulse_start();
    check("restart_done_clr", 64'(done), 64'd0);
    load(1'b1, 1'b1);
    wait_end("thr_timeout");
    expect_done("thr", 2);

    // zero-length image
    stim = '{8'h00, 8'h00};
    writes = 0;
    pulse_start();
    load(1'b0, 1'b1);
    check("zero_done", 64'(done), 64'd1);
    check("zero_cpu_rst", 64'(cpu_rst), 64'd0);
    check("zero_writes", 64'(writes), 64'd0);

    // oversize image: 1025 words
    stim = '{8'h01, 8'h04};
    writes = 0;
    pulse_start();
    load(1'b0, 1'b0);
    check("big_error", 64'(error), 64'd1);
    check("big_cpu_rst", 64'(cpu_rst), 64'd1);
    check("big_in_ready", 64'(in_ready), 64'd0);
    check("big_done", 64'(done), 64'd0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("big_hold_in_ready", 64'(in_ready), 64'd0);
    check("big_writes", 64'(writes), 64'd0);
    in_valid = 1'b0;

    // reset mid-load, then reload with a stray start inside DATA
    stim = '{8'h02, 8'h00, 8'hAA, 8'hBB};
    writes = 0;
    pulse_start();
    load(1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    #1 rst = 1'b0;
    exp_q.push_back('{32'd0, 32'h44332211});
    pulse_start();
    send(8'h01);
    send(8'h00);
    send(8'h11);
    pulse_start();
    check("busy_start_ignored", 64'(busy), 64'd1);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    if (use_csum) send(8'h45);
    wait_end("reload_timeout");
    expect_done("reload", 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back('{32'd0, 32'h44332211});
    writes = 0;
    pulse_start();
    load(1'b0, 1'b0);
    send(8'h45);
    check("csum_ok_done", 64'(done), 64'd1);
    check("csum_ok_cpu_rst", 64'(cpu_rst), 64'd0);
    check("csum_ok_writes", 64'(writes), 64'd1);
    exp_q.push_back('{32'd0, 32'h44332211});
    writes = 0;
    pulse_start();
    load(1'b0, 1'b0);
    send(8'h00);
    check("csum_bad_error", 64'(error), 64'd1);
    check("csum_bad_done", 64'(done), 64'd0);
    check("csum_bad_cpu_rst", 64'(cpu_rst), 64'd1);
    check("csum_bad_writes", 64'(writes), 64'd1);
`endif

    repeat (3) @(posedge clk);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
